// File: rtl/m_arb_pkg.sv
// Shared types, constants and the M-extension decode helper for the M-unit arbiter.
package m_arb_pkg;

   localparam int unsigned XLEN = 32;

   localparam logic [6:0] OPCODE_OP     = 7'b0110011;
   localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      DONE  = 2'd3
   } state_e;

   typedef struct packed {
      logic [XLEN-1:0] instruction;
      logic [XLEN-1:0] rs1;
      logic [XLEN-1:0] rs2;
   } m_op_t;

   function automatic logic is_muldiv(input logic [XLEN-1:0] instruction);
      return (instruction[6:0] == OPCODE_OP) && (instruction[31:25] == FUNCT7_MULDIV);
   endfunction

endpackage

// File: rtl/m_unit_arbiter_if.sv
// Requester-side PCPI ports and M-unit port bundled for the arbiter.
interface m_unit_arbiter_if
   import m_arb_pkg::*;
#(
   parameter int unsigned NUM_REQ = 2
);
   logic [NUM_REQ-1:0]           req_valid;
   logic [NUM_REQ-1:0][XLEN-1:0] req_instruction;
   logic [NUM_REQ-1:0][XLEN-1:0] req_rs1;
   logic [NUM_REQ-1:0][XLEN-1:0] req_rs2;
   logic [NUM_REQ-1:0]           req_busy;
   logic [NUM_REQ-1:0]           req_ready;
   logic [NUM_REQ-1:0]           req_wr;
   logic [NUM_REQ-1:0]           req_err;
   logic [XLEN-1:0]              req_rd;

   logic                         m_valid;
   logic [XLEN-1:0]              m_instruction;
   logic [XLEN-1:0]              m_rs1;
   logic [XLEN-1:0]              m_rs2;
   logic                         m_wr;
   logic [XLEN-1:0]              m_rd;
   logic                         m_busy;
   logic                         m_ready;

   // Arbiter view
   modport slave (
      input  req_valid, req_instruction, req_rs1, req_rs2,
      output req_busy, req_ready, req_wr, req_err, req_rd,
      output m_valid, m_instruction, m_rs1, m_rs2,
      input  m_wr, m_rd, m_busy, m_ready
   );

   // Environment view: requesters plus the M unit
   modport master (
      output req_valid, req_instruction, req_rs1, req_rs2,
      input  req_busy, req_ready, req_wr, req_err, req_rd,
      input  m_valid, m_instruction, m_rs1, m_rs2,
      output m_wr, m_rd, m_busy, m_ready
   );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first request at or after ptr_i, wrapping.
module rr_arbiter #(
   parameter int unsigned N  = 2,
   parameter int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req_i,
   input  logic [IW-1:0] ptr_i,
   output logic [N-1:0]  gnt_c,
   output logic [IW-1:0] idx_c
);

   logic        found;
   int unsigned cand;

   always_comb begin
      gnt_c = '0;
      idx_c = '0;
      found = 1'b0;
      cand  = 0;
      for (int unsigned k = 0; k < N; k++) begin
         cand = (32'(ptr_i) + k) % N;
         if (!found && req_i[IW'(cand)]) begin
            found              = 1'b1;
            gnt_c[IW'(cand)]   = 1'b1;
            idx_c              = IW'(cand);
         end
      end
   end

endmodule

// File: rtl/m_unit_arbiter.sv
// Shares one PCPI M-extension unit between NUM_REQ requesters with round-robin grant,
// no-ack abort and result routing back to the owning requester.
module m_unit_arbiter
   import m_arb_pkg::*;
#(
   parameter int unsigned NUM_REQ      = 2,
   parameter int unsigned NOACK_CYCLES = 16
) (
   input  logic             clk,
   input  logic             reset,
   m_unit_arbiter_if.slave  bus
);

   localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int unsigned CNT_W = $clog2(NOACK_CYCLES + 1);

   state_e             state_q, state_d;
   logic [IDX_W-1:0]   owner_q, owner_d;
   logic [IDX_W-1:0]   ptr_q, ptr_d;
   m_op_t              op_q, op_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               flush_q, flush_d;
   logic               m_valid_q, m_valid_d;
   logic [NUM_REQ-1:0] ready_q, ready_d;
   logic [NUM_REQ-1:0] wr_q, wr_d;
   logic [NUM_REQ-1:0] err_q, err_d;
   logic [XLEN-1:0]    rd_q, rd_d;

   logic [NUM_REQ-1:0] eligible_c;
   logic [NUM_REQ-1:0] gnt_c;
   logic [IDX_W-1:0]   gnt_idx_c;
   logic               flush_c;

   always_comb begin
      eligible_c = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++)
         eligible_c[i] = bus.req_valid[i] && is_muldiv(bus.req_instruction[i]);
   end

   // Busy holds waiting requesters off their own no-ack timeout
   assign bus.req_busy = reset ? '0 : eligible_c;

   rr_arbiter #(.N(NUM_REQ), .IW(IDX_W)) u_rr (
      .req_i (eligible_c),
      .ptr_i (ptr_q),
      .gnt_c (gnt_c),
      .idx_c (gnt_idx_c)
   );

   // Owner withdrew at some point during the op: its result must be dropped
   assign flush_c = flush_q | ~bus.req_valid[owner_q];

   always_comb begin
      state_d   = state_q;
      owner_d   = owner_q;
      ptr_d     = ptr_q;
      op_d      = op_q;
      cnt_d     = cnt_q;
      flush_d   = flush_q;
      m_valid_d = 1'b0;
      ready_d   = '0;
      wr_d      = '0;
      err_d     = '0;
      rd_d      = '0;

      unique case (state_q)
         IDLE: begin
            if (|gnt_c) begin
               owner_d        = gnt_idx_c;
               ptr_d          = (gnt_idx_c == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx_c + IDX_W'(1);
               op_d.instruction = bus.req_instruction[gnt_idx_c];
               op_d.rs1       = bus.req_rs1[gnt_idx_c];
               op_d.rs2       = bus.req_rs2[gnt_idx_c];
               cnt_d          = '0;
               flush_d        = 1'b0;
               m_valid_d      = 1'b1;
               state_d        = ISSUE;
            end
         end
         ISSUE, WAIT: begin
            m_valid_d = 1'b1;
            flush_d   = flush_c;
            if (state_q == ISSUE && cnt_q != CNT_W'(NOACK_CYCLES))
               cnt_d = cnt_q + CNT_W'(1);
            if (bus.m_ready) begin
               state_d   = DONE;
               m_valid_d = 1'b0;
               if (!flush_c) begin
                  ready_d[owner_q] = 1'b1;
                  wr_d[owner_q]    = bus.m_wr;
                  rd_d             = bus.m_rd;
               end
            end else if (state_q == ISSUE && bus.m_busy) begin
               state_d = WAIT;
            end else if (state_q == ISSUE && cnt_q == CNT_W'(NOACK_CYCLES)) begin
               state_d   = DONE;
               m_valid_d = 1'b0;
               if (!flush_c)
                  err_d[owner_q] = 1'b1;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         owner_q   <= '0;
         ptr_q     <= '0;
         op_q      <= '0;
         cnt_q     <= '0;
         flush_q   <= 1'b0;
         m_valid_q <= 1'b0;
         ready_q   <= '0;
         wr_q      <= '0;
         err_q     <= '0;
         rd_q      <= '0;
      end else begin
         state_q   <= state_d;
         owner_q   <= owner_d;
         ptr_q     <= ptr_d;
         op_q      <= op_d;
         cnt_q     <= cnt_d;
         flush_q   <= flush_d;
         m_valid_q <= m_valid_d;
         ready_q   <= ready_d;
         wr_q      <= wr_d;
         err_q     <= err_d;
         rd_q      <= rd_d;
      end
   end

   assign bus.m_valid       = m_valid_q;
   assign bus.m_instruction = op_q.instruction;
   assign bus.m_rs1         = op_q.rs1;
   assign bus.m_rs2         = op_q.rs2;
   assign bus.req_ready     = ready_q;
   assign bus.req_wr        = wr_q;
   assign bus.req_err       = err_q;
   assign bus.req_rd        = rd_q;

endmodule

// File: tb/tb_m_unit_arbiter.sv
// Directed bench for m_unit_arbiter: the bench plays both requesters and the M unit.
module tb_m_unit_arbiter;

   localparam logic [31:0] MUL_I = 32'h02c5_8533;
   localparam logic [31:0] DIV_I = 32'h02c5_c533;
   localparam logic [31:0] ADD_I = 32'h00b5_0533;

   logic clk = 1'b0;
   logic reset;
   int unsigned n_tests = 0;
   int unsigned n_fail  = 0;

   always #5 clk = ~clk;

   m_unit_arbiter_if #(.NUM_REQ(2)) bus ();

   m_unit_arbiter #(.NUM_REQ(2), .NOACK_CYCLES(16)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic chk_rsp(input string tag, input logic [1:0] rdy, input logic [1:0] wr,
                          input logic [1:0] err, input logic [31:0] rd);
      chk({tag, ".ready"}, 32'(bus.req_ready), 32'(rdy));
      chk({tag, ".wr"},    32'(bus.req_wr),    32'(wr));
      chk({tag, ".err"},   32'(bus.req_err),   32'(err));
      chk({tag, ".rd"},    bus.req_rd,         rd);
   endtask

   task automatic cyc;
      @(posedge clk);
      #1;
   endtask

   task automatic samp;
      @(negedge clk);
   endtask

   task automatic req(input int unsigned i, input logic v, input logic [31:0] ins,
                      input logic [31:0] a, input logic [31:0] b);
      bus.req_valid[i]       = v;
      bus.req_instruction[i] = ins;
      bus.req_rs1[i]         = a;
      bus.req_rs2[i]         = b;
   endtask

   task automatic unit(input logic busy, input logic rdy, input logic wr, input logic [31:0] rd);
      bus.m_busy  = busy;
      bus.m_ready = rdy;
      bus.m_wr    = wr;
      bus.m_rd    = rd;
   endtask

   initial begin
      reset = 1'b1;
      req(0, 1'b0, 32'h0, 32'h0, 32'h0);
      req(1, 1'b0, 32'h0, 32'h0, 32'h0);
      unit(1'b0, 1'b0, 1'b0, 32'h0);
      repeat (3) cyc();
      samp();
      chk_rsp("rst", 2'b00, 2'b00, 2'b00, 32'h0);
      chk("rst.m_valid", 32'(bus.m_valid), 32'h0);
      chk("rst.m_rs1", bus.m_rs1, 32'h0);
      cyc();
      reset = 1'b0;

      // Single MUL, unit answers one cycle after seeing m_valid
      cyc();
      req(0, 1'b1, MUL_I, 32'd7, 32'd6);
      samp();
      chk("mul.busy_c0", 32'(bus.req_busy), 32'h1);
      chk("mul.m_valid_c0", 32'(bus.m_valid), 32'h0);
      cyc();
      samp();
      chk("mul.m_valid_c1", 32'(bus.m_valid), 32'h1);
      chk("mul.m_instr", bus.m_instruction, MUL_I);
      chk("mul.m_rs1", bus.m_rs1, 32'd7);
      chk("mul.m_rs2", bus.m_rs2, 32'd6);
      cyc();
      unit(1'b0, 1'b1, 1'b1, 32'd42);
      samp();
      chk("mul.m_valid_c2", 32'(bus.m_valid), 32'h1);
      chk_rsp("mul.c2", 2'b00, 2'b00, 2'b00, 32'h0);
      cyc();
      unit(1'b0, 1'b0, 1'b0, 32'h0);
      samp();
      chk_rsp("mul.c3", 2'b01, 2'b01, 2'b00, 32'd42);
      chk("mul.m_valid_c3", 32'(bus.m_valid), 32'h0);
      cyc();
      req(0, 1'b0, 32'h0, 32'h0, 32'h0);
      samp();
      chk_rsp("mul.c4", 2'b00, 2'b00, 2'b00, 32'h0);

      // Non-M instruction is ignored; stray m_ready in IDLE is ignored too
      cyc();
      req(1, 1'b1, ADD_I, 32'd1, 32'd2);
      unit(1'b0, 1'b1, 1'b1, 32'hdead);
      for (int k = 0; k < 3; k++) begin
         samp();
         chk("add.busy", 32'(bus.req_busy), 32'h0);
         chk("add.m_valid", 32'(bus.m_valid), 32'h0);
         chk_rsp("add", 2'b00, 2'b00, 2'b00, 32'h0);
         cyc();
      end
      req(1, 1'b0, 32'h0, 32'h0, 32'h0);
      unit(1'b0, 1'b0, 1'b0, 32'h0);

      // No-ack: err pulse exactly at cycle NOACK_CYCLES+2
      cyc();
      req(0, 1'b1, MUL_I, 32'd3, 32'd5);
      samp();
      chk("noack.busy", 32'(bus.req_busy), 32'h1);
      for (int c = 1; c <= 18; c++) begin
         cyc();
         samp();
         if (c < 18) begin
            chk("noack.m_valid", 32'(bus.m_valid), 32'h1);
            chk("noack.err_early", 32'(bus.req_err), 32'h0);
         end else begin
            chk_rsp("noack.c18", 2'b00, 2'b00, 2'b01, 32'h0);
            chk("noack.m_valid_c18", 32'(bus.m_valid), 32'h0);
         end
      end
      cyc();
      req(0, 1'b0, 32'h0, 32'h0, 32'h0);
      samp();
      chk_rsp("noack.c19", 2'b00, 2'b00, 2'b00, 32'h0);
      chk("noack.m_valid_c19", 32'(bus.m_valid), 32'h0);

      // Flush: req0 withdraws during a long DIV, pending req1 follows
      cyc();
      req(0, 1'b1, DIV_I, 32'd100, 32'd7);
      samp();
      chk("flush.busy_c0", 32'(bus.req_busy), 32'h1);
      cyc();
      unit(1'b1, 1'b0, 1'b0, 32'h0);
      samp();
      chk("flush.m_instr", bus.m_instruction, DIV_I);
      for (int c = 2; c <= 34; c++) begin
         cyc();
         if (c == 5) begin
            req(0, 1'b0, 32'h0, 32'h0, 32'h0);
            req(1, 1'b1, MUL_I, 32'd5, 32'd9);
         end
         samp();
         if (c == 5) chk("flush.busy_c5", 32'(bus.req_busy), 32'h2);
         if (c == 34) begin
            chk("flush.m_valid_c34", 32'(bus.m_valid), 32'h1);
            chk("flush.ready_c34", 32'(bus.req_ready), 32'h0);
         end
      end
      cyc();
      unit(1'b1, 1'b1, 1'b1, 32'd14);
      samp();
      chk("flush.m_valid_c35", 32'(bus.m_valid), 32'h1);
      cyc();
      unit(1'b0, 1'b0, 1'b0, 32'h0);
      samp();
      chk_rsp("flush.c36", 2'b00, 2'b00, 2'b00, 32'h0);
      chk("flush.m_valid_c36", 32'(bus.m_valid), 32'h0);
      chk("flush.busy_c36", 32'(bus.req_busy), 32'h2);
      cyc();
      samp();
      chk("flush.m_valid_c37", 32'(bus.m_valid), 32'h0);
      cyc();
      samp();
      chk("flush.m_valid_c38", 32'(bus.m_valid), 32'h1);
      chk("flush.m_rs1_c38", bus.m_rs1, 32'd5);
      cyc();
      unit(1'b0, 1'b1, 1'b1, 32'd99);
      cyc();
      unit(1'b0, 1'b0, 1'b0, 32'h0);
      samp();
      chk_rsp("flush.req1", 2'b10, 2'b10, 2'b00, 32'd99);
      cyc();
      req(1, 1'b0, 32'h0, 32'h0, 32'h0);

      // Reset while in WAIT clears everything without a clock edge
      cyc();
      req(0, 1'b1, MUL_I, 32'd3, 32'd4);
      cyc();
      unit(1'b1, 1'b0, 1'b0, 32'h0);
      cyc();
      samp();
      chk("rstw.m_valid_pre", 32'(bus.m_valid), 32'h1);
      cyc();
      reset = 1'b1;
      #1;
      chk("rstw.m_valid", 32'(bus.m_valid), 32'h0);
      chk("rstw.busy", 32'(bus.req_busy), 32'h0);
      chk("rstw.m_rs1", bus.m_rs1, 32'h0);
      chk_rsp("rstw", 2'b00, 2'b00, 2'b00, 32'h0);
      cyc();
      reset = 1'b0;
      req(0, 1'b0, 32'h0, 32'h0, 32'h0);
      unit(1'b0, 1'b0, 1'b0, 32'h0);
      samp();
      chk("rstw.m_valid_after", 32'(bus.m_valid), 32'h0);
      chk_rsp("rstw.after", 2'b00, 2'b00, 2'b00, 32'h0);

      // Contention after reset: req0 first, then req1 beats a re-raising req0
      cyc();
      req(0, 1'b1, DIV_I, 32'd100, 32'd7);
      req(1, 1'b1, DIV_I, 32'd50, 32'd5);
      samp();
      chk("cont.busy_c0", 32'(bus.req_busy), 32'h3);
      cyc();
      unit(1'b1, 1'b0, 1'b0, 32'h0);
      samp();
      chk("cont.m_rs1_c1", bus.m_rs1, 32'd100);
      for (int c = 2; c <= 3; c++) begin
         cyc();
         samp();
         chk_rsp("cont.wait", 2'b00, 2'b00, 2'b00, 32'h0);
         chk("cont.busy_wait", 32'(bus.req_busy), 32'h3);
      end
      cyc();
      unit(1'b0, 1'b1, 1'b1, 32'd14);
      cyc();
      unit(1'b0, 1'b0, 1'b0, 32'h0);
      samp();
      chk_rsp("cont.r0", 2'b01, 2'b01, 2'b00, 32'd14);
      cyc();
      req(0, 1'b1, MUL_I, 32'd3, 32'd3);
      samp();
      chk("cont.m_valid_c6", 32'(bus.m_valid), 32'h0);
      cyc();
      samp();
      chk("cont.m_valid_c7", 32'(bus.m_valid), 32'h1);
      chk("cont.m_rs1_c7", bus.m_rs1, 32'd50);
      cyc();
      unit(1'b1, 1'b1, 1'b1, 32'd10);
      cyc();
      unit(1'b0, 1'b0, 1'b0, 32'h0);
      samp();
      chk_rsp("cont.r1", 2'b10, 2'b10, 2'b00, 32'd10);
      chk("cont.busy_c9", 32'(bus.req_busy), 32'h3);
      cyc();
      req(1, 1'b0, 32'h0, 32'h0, 32'h0);
      cyc();
      samp();
      chk("cont.m_rs1_c11", bus.m_rs1, 32'd3);
      chk("cont.m_valid_c11", 32'(bus.m_valid), 32'h1);
      cyc();
      unit(1'b0, 1'b1, 1'b1, 32'd9);
      cyc();
      unit(1'b0, 1'b0, 1'b0, 32'h0);
      samp();
      chk_rsp("cont.r0b", 2'b01, 2'b01, 2'b00, 32'd9);
      cyc();
      req(0, 1'b0, 32'h0, 32'h0, 32'h0);
      cyc();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
